// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: UART receive stage. Synchronises the serial line, detects a
// start edge, samples each bit at mid-bit using an oversampling tick, and
// delivers the parallel word together with parity and framing status.
module uart_rx_sipo #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       rx_active,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Line synchroniser and edge detector.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_d_q, rx_d_d;
    logic                   rx_s;

    // Receive FSM state and per-frame working registers.
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic          stop_idx_q, stop_idx_d;
    logic          stop_err_q, stop_err_d;

    // Frame configuration captured at start-edge time.
    logic [1:0] cfg_par_q, cfg_par_d;
    logic       cfg_stop2_q, cfg_stop2_d;
    logic       cfg_len8_q, cfg_len8_d;

    // Registered outputs.
    logic [7:0] data_out_q, data_out_d;
    logic       rx_done_q, rx_done_d;
    logic       rx_active_q, rx_active_d;
    logic       parity_error_q, parity_error_d;
    logic       stop_error_q, stop_error_d;

    logic       par_en;
    logic       par_odd;
    logic [2:0] last_idx;
    logic       par_xor;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign par_en   = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
    assign par_odd  = (cfg_par_q == 2'b01);
    assign last_idx = cfg_len8_q ? 3'd7 : 3'd6;
    // Bit 7 of the shift register stays 0 in 7-bit frames, so it never
    // disturbs the parity sum.
    assign par_xor  = (^shift_q) ^ par_bit_q;

    // Synchroniser shift and one-clk delayed copy for start-edge detection.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
        rx_d_d = rx_s;
    end

    // Receive FSM: edge detect, mid-bit sampling, frame completion.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        par_bit_d      = par_bit_q;
        stop_idx_d     = stop_idx_q;
        stop_err_d     = stop_err_q;
        cfg_par_d      = cfg_par_q;
        cfg_stop2_d    = cfg_stop2_q;
        cfg_len8_d     = cfg_len8_q;
        data_out_d     = data_out_q;
        rx_done_d      = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;

        case (state_q)
            S_IDLE: begin
                if (rx_d_q && !rx_s) begin
                    state_d     = S_START;
                    cnt_d       = '0;
                    cfg_par_d   = parity_type;
                    cfg_stop2_d = stop_bits;
                    cfg_len8_d  = data_length;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    if (cnt_q == MID) begin
                        if (!rx_s) begin
                            cnt_d     = '0;
                            shift_d   = '0;
                            bit_idx_d = '0;
                            state_d   = S_DATA;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d              = '0;
                        shift_d[bit_idx_q] = rx_s;
                        if (bit_idx_q == last_idx) begin
                            state_d    = par_en ? S_PARITY : S_STOP;
                            stop_idx_d = 1'b0;
                            stop_err_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (baud_tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d     = '0;
                        par_bit_d = rx_s;
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_STOP: begin
                if (baud_tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d      = '0;
                        stop_err_d = stop_err_q | ~rx_s;
                        if (stop_idx_q == cfg_stop2_q) begin
                            // Final stop sample: publish the frame and leave
                            // at mid-bit so a following start edge is caught.
                            state_d        = S_IDLE;
                            data_out_d     = {cfg_len8_q & shift_q[7], shift_q[6:0]};
                            parity_error_d = par_en & (par_odd ? ~par_xor : par_xor);
                            stop_error_d   = stop_err_q | ~rx_s;
                            rx_done_d      = 1'b1;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        rx_active_d = (state_d != S_IDLE);
    end

    // State registers; the synchroniser resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q         <= '1;
            rx_d_q         <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_bit_q      <= 1'b0;
            stop_idx_q     <= 1'b0;
            stop_err_q     <= 1'b0;
            cfg_par_q      <= 2'b00;
            cfg_stop2_q    <= 1'b0;
            cfg_len8_q     <= 1'b1;
            data_out_q     <= 8'h00;
            rx_done_q      <= 1'b0;
            rx_active_q    <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            sync_q         <= sync_d;
            rx_d_q         <= rx_d_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            par_bit_q      <= par_bit_d;
            stop_idx_q     <= stop_idx_d;
            stop_err_q     <= stop_err_d;
            cfg_par_q      <= cfg_par_d;
            cfg_stop2_q    <= cfg_stop2_d;
            cfg_len8_q     <= cfg_len8_d;
            data_out_q     <= data_out_d;
            rx_done_q      <= rx_done_d;
            rx_active_q    <= rx_active_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign data_out     = data_out_q;
    assign rx_done      = rx_done_q;
    assign rx_active    = rx_active_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule
